// File: rtl/matmul_pkg.sv
// Shared types and derived-constant helpers for the matmul tile sequencer.
package matmul_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 14;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_RD   = 3'd2,
        STEP      = 3'd3,
        WAIT_STEP = 3'd4,
        WAIT_ACC  = 3'd5,
        WRITE     = 3'd6,
        DONE      = 3'd7
    } seq_state_e;

    // Number of k-steps per output tile.
    function automatic int unsigned k_steps(input int unsigned inner_dim, input int unsigned block);
        return inner_dim / block;
    endfunction

    // Number of row tiles in C.
    function automatic int unsigned row_tiles(input int unsigned i_outer, input int unsigned block);
        return i_outer / block;
    endfunction

    // Number of column groups in C; each group spans all parallel lanes.
    function automatic int unsigned col_groups(input int unsigned w_outer, input int unsigned block,
                                               input int unsigned cores);
        return w_outer / (block * cores);
    endfunction

endpackage

// File: rtl/tile_counter.sv
// Wrap counter with synchronous clear, increment and a wrap strobe for chaining.
module tile_counter #(
    parameter int unsigned W   = 14,
    parameter int unsigned MAX = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_nxt_c,
    output logic         o_wrap_c
);

    logic [W-1:0] r_count;
    logic         w_last;

    assign w_last   = (r_count == W'(MAX - 1));
    assign o_wrap_c = i_inc & w_last;
    assign o_count  = r_count;

    // Next count: clear wins, then increment with wrap.
    always_comb begin
        o_nxt_c = r_count;
        if (i_clr) begin
            o_nxt_c = '0;
        end else if (i_inc) begin
            o_nxt_c = w_last ? '0 : r_count + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= o_nxt_c;
        end
    end

endmodule

// File: rtl/matmul_tile_sequencer.sv
// Tile scheduler for the blocked matrix multiplier: BRAM addressing, core pacing, tile writes.
module matmul_tile_sequencer
    import matmul_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE        = 2,
    parameter int unsigned INNER_DIMENSION   = 4,
    parameter int unsigned I_OUTER_DIMENSION = 6,
    parameter int unsigned W_OUTER_DIMENSION = 6,
    parameter int unsigned NUM_CORES         = 1,
    parameter int unsigned BRAM_LATENCY      = 1,
    parameter int unsigned ADDR_WIDTH        = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_start,
    output logic                  o_ready,
    output logic                  o_done,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_in_addrb,
    output logic [ADDR_WIDTH-1:0] o_wb_addrb,
    output logic                  o_core_valid,
    output logic                  o_reset_acc,
    output logic                  o_core_last,
    input  logic                  i_core_step_done,
    input  logic                  i_acc_done,
    output logic                  o_out_we,
    output logic [ADDR_WIDTH-1:0] o_out_addr,
    output logic [ADDR_WIDTH-1:0] o_cur_row,
    output logic [ADDR_WIDTH-1:0] o_cur_col
);

    localparam int unsigned K_STEPS    = k_steps(INNER_DIMENSION, BLOCK_SIZE);
    localparam int unsigned ROW_TILES  = row_tiles(I_OUTER_DIMENSION, BLOCK_SIZE);
    localparam int unsigned COL_GROUPS = col_groups(W_OUTER_DIMENSION, BLOCK_SIZE, NUM_CORES);
    localparam int unsigned LAT_W      = 3;
    localparam int unsigned LAT_LAST   = (BRAM_LATENCY > 1) ? BRAM_LATENCY - 2 : 0;
    localparam longint unsigned ADDR_SPAN = 64'(1) << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] KS_A     = ADDR_WIDTH'(K_STEPS);
    localparam logic [ADDR_WIDTH-1:0] CG_A     = ADDR_WIDTH'(COL_GROUPS);
    localparam logic [ADDR_WIDTH-1:0] K_LAST_A = ADDR_WIDTH'(K_STEPS - 1);

    // Elaboration-time parameter legality.
    if (BLOCK_SIZE == 0 || NUM_CORES == 0) begin : g_chk_zero
        $error("BLOCK_SIZE and NUM_CORES must be non-zero");
    end
    if (INNER_DIMENSION % BLOCK_SIZE != 0 || INNER_DIMENSION == 0) begin : g_chk_k
        $error("INNER_DIMENSION must be a non-zero multiple of BLOCK_SIZE");
    end
    if (I_OUTER_DIMENSION % BLOCK_SIZE != 0 || I_OUTER_DIMENSION == 0) begin : g_chk_i
        $error("I_OUTER_DIMENSION must be a non-zero multiple of BLOCK_SIZE");
    end
    if (W_OUTER_DIMENSION % (BLOCK_SIZE * NUM_CORES) != 0 || W_OUTER_DIMENSION == 0) begin : g_chk_w
        $error("W_OUTER_DIMENSION must be a non-zero multiple of BLOCK_SIZE*NUM_CORES");
    end
    if (BRAM_LATENCY < 1 || BRAM_LATENCY > 4) begin : g_chk_lat
        $error("BRAM_LATENCY must be in 1..4");
    end
    if (longint'(ROW_TILES) * longint'(K_STEPS) > ADDR_SPAN ||
        longint'(COL_GROUPS) * longint'(K_STEPS) > ADDR_SPAN ||
        longint'(ROW_TILES) * longint'(COL_GROUPS) > ADDR_SPAN) begin : g_chk_ovf
        $error("address products overflow ADDR_WIDTH");
    end

    seq_state_e r_state;
    seq_state_e w_state_nxt;

    logic [LAT_W-1:0]      r_lat_cnt;
    logic                  r_acc_flag;
    logic                  r_ready, r_done, r_rd_en, r_core_valid, r_reset_acc, r_core_last, r_out_we;
    logic [ADDR_WIDTH-1:0] r_in_addrb, r_wb_addrb, r_out_addr;

    logic                  w_ready_nxt, w_done_nxt, w_rd_en_nxt, w_core_valid_nxt;
    logic                  w_reset_acc_nxt, w_core_last_nxt, w_out_we_nxt;
    logic                  w_cnt_clr, w_k_inc, w_col_inc;
    logic                  w_k_wrap, w_col_wrap, w_row_wrap;
    logic                  w_k_last, w_acc_window;
    logic [ADDR_WIDTH-1:0] w_k, w_col, w_row, w_k_nxt, w_col_nxt, w_row_nxt;
    logic [ADDR_WIDTH-1:0] w_in_addr_nxt, w_wb_addr_nxt, w_out_addr_nxt;

    assign w_cnt_clr = i_clr | ((r_state == IDLE) & i_start);
    assign w_k_inc   = (r_state == WAIT_STEP) & i_core_step_done;
    assign w_col_inc = (r_state == WRITE);

    tile_counter #(.W(ADDR_WIDTH), .MAX(K_STEPS)) u_k_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_cnt_clr),
        .i_inc    (w_k_inc),
        .o_count  (w_k),
        .o_nxt_c  (w_k_nxt),
        .o_wrap_c (w_k_wrap)
    );

    tile_counter #(.W(ADDR_WIDTH), .MAX(COL_GROUPS)) u_col_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_cnt_clr),
        .i_inc    (w_col_inc),
        .o_count  (w_col),
        .o_nxt_c  (w_col_nxt),
        .o_wrap_c (w_col_wrap)
    );

    tile_counter #(.W(ADDR_WIDTH), .MAX(ROW_TILES)) u_row_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_cnt_clr),
        .i_inc    (w_col_wrap),
        .o_count  (w_row),
        .o_nxt_c  (w_row_nxt),
        .o_wrap_c (w_row_wrap)
    );

    assign w_k_last       = (w_k == K_LAST_A);
    assign w_acc_window   = (((r_state == STEP) || (r_state == WAIT_STEP)) && w_k_last) ||
                            (r_state == WAIT_ACC);
    assign w_in_addr_nxt  = w_row_nxt * KS_A + w_k_nxt;
    assign w_wb_addr_nxt  = w_col_nxt * KS_A + w_k_nxt;
    assign w_out_addr_nxt = w_row_nxt * CG_A + w_col_nxt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; clr overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (i_start) w_state_nxt = ISSUE;
            ISSUE:     w_state_nxt = (BRAM_LATENCY == 1) ? STEP : WAIT_RD;
            WAIT_RD:   if (r_lat_cnt == LAT_W'(LAT_LAST)) w_state_nxt = STEP;
            STEP:      w_state_nxt = WAIT_STEP;
            WAIT_STEP: if (i_core_step_done) w_state_nxt = w_k_wrap ? WAIT_ACC : ISSUE;
            WAIT_ACC:  if (r_acc_flag || i_acc_done) w_state_nxt = WRITE;
            WRITE:     w_state_nxt = w_row_wrap ? DONE : ISSUE;
            DONE:      w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
        if (i_clr) w_state_nxt = IDLE;

        w_ready_nxt      = (w_state_nxt == IDLE);
        w_done_nxt       = (w_state_nxt == DONE);
        w_rd_en_nxt      = (w_state_nxt == ISSUE);
        w_core_valid_nxt = (w_state_nxt == STEP);
        w_reset_acc_nxt  = (w_state_nxt == STEP) && (w_k_nxt == '0);
        w_core_last_nxt  = (w_state_nxt == STEP) && (w_k_nxt == K_LAST_A);
        w_out_we_nxt     = (w_state_nxt == WRITE);
    end

    // BRAM latency wait counter, running only in WAIT_RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_cnt <= '0;
        end else if (r_state == WAIT_RD) begin
            r_lat_cnt <= r_lat_cnt + LAT_W'(1);
        end else begin
            r_lat_cnt <= '0;
        end
    end

    // Sticky acc_done so an early accumulator result is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_flag <= 1'b0;
        end else if (i_clr || (w_state_nxt == WRITE)) begin
            r_acc_flag <= 1'b0;
        end else if (i_acc_done && w_acc_window) begin
            r_acc_flag <= 1'b1;
        end
    end

    // Registered outputs; addresses load on ISSUE / WRITE entry and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready      <= 1'b1;
            r_done       <= 1'b0;
            r_rd_en      <= 1'b0;
            r_core_valid <= 1'b0;
            r_reset_acc  <= 1'b0;
            r_core_last  <= 1'b0;
            r_out_we     <= 1'b0;
            r_in_addrb   <= '0;
            r_wb_addrb   <= '0;
            r_out_addr   <= '0;
        end else begin
            r_ready      <= w_ready_nxt;
            r_done       <= w_done_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_core_valid <= w_core_valid_nxt;
            r_reset_acc  <= w_reset_acc_nxt;
            r_core_last  <= w_core_last_nxt;
            r_out_we     <= w_out_we_nxt;
            if (w_rd_en_nxt) begin
                r_in_addrb <= w_in_addr_nxt;
                r_wb_addrb <= w_wb_addr_nxt;
            end
            if (w_out_we_nxt) begin
                r_out_addr <= w_out_addr_nxt;
            end
        end
    end

    assign o_ready      = r_ready;
    assign o_done       = r_done;
    assign o_rd_en      = r_rd_en;
    assign o_in_addrb   = r_in_addrb;
    assign o_wb_addrb   = r_wb_addrb;
    assign o_core_valid = r_core_valid;
    assign o_reset_acc  = r_reset_acc;
    assign o_core_last  = r_core_last;
    assign o_out_we     = r_out_we;
    assign o_out_addr   = r_out_addr;
    assign o_cur_row    = w_row;
    assign o_cur_col    = w_col;

endmodule
